// File: rtl/shift_chain_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_chain_ctrl_pkg
// Shared types and default geometry for the serial shift-chain sequencer.
//   state_t          : controller FSM states
//   DEF_WIDTH        : default bits per transfer word
//   DEF_CHAIN_DEPTH  : default register stages in the attached chain
// -----------------------------------------------------------------------------
package shift_chain_ctrl_pkg;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_CHAIN_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT,
        RESP
    } state_t;

endpackage

// File: rtl/shift_chain_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_chain_ctrl_if
// Parallel request/response bundle between a requester and the shift-chain
// sequencer.
//   req_valid / req_ready / req_data : request word handshake
//   rsp_valid / rsp_ready / rsp_data : response word handshake
//   rsp_err                          : response differs from the word sent
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface shift_chain_ctrl_if
    import shift_chain_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/shift_chain_ctrl.sv
// -----------------------------------------------------------------------------
// shift_chain_ctrl
// Sequences one transfer through a CHAIN_DEPTH-stage serial shift chain:
// accept a word, clear the chain for one cycle, shift the word in LSB-first,
// collect the bits that emerge CHAIN_DEPTH cycles later, and return them with
// a loopback-mismatch flag.
// Ports:
//   clock      : single clock, rising edge
//   reset      : asynchronous, active-low
//   bus        : request/response handshake (slave side)
//   chain_clr  : synchronous active-high clear to the chain (registered)
//   chain_in   : serial bit into the chain (registered)
//   chain_out  : serial bit from the chain's last stage
//   busy       : high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module shift_chain_ctrl
    import shift_chain_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned CHAIN_DEPTH = DEF_CHAIN_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    shift_chain_ctrl_if.slave bus,
    output logic              chain_clr,
    output logic              chain_in,
    input  logic              chain_out,
    output logic              busy
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + CHAIN_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH + CHAIN_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CHAIN_DEPTH);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] tx_shreg;
    logic [WIDTH-1:0] tx_copy;
    logic [WIDTH-1:0] rx_shreg;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (bus.req_valid)     state_next = CLEAR;
            CLEAR:                          state_next = SHIFT;
            SHIFT:   if (cnt == CNT_LAST)   state_next = RESP;
            RESP:    if (bus.rsp_ready)     state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // Datapath and registered chain controls. chain_clr resets high so the
    // chain is held clear through reset and released on the first edge after.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            tx_shreg  <= '0;
            tx_copy   <= '0;
            rx_shreg  <= '0;
            chain_clr <= 1'b1;
            chain_in  <= 1'b0;
        end else begin
            chain_clr <= (state_next == CLEAR);
            chain_in  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        tx_shreg <= bus.req_data;
                        tx_copy  <= bus.req_data;
                    end
                end
                CLEAR: begin
                    // Pre-load bit 0 so it is on chain_in during cnt = 0.
                    cnt      <= '0;
                    chain_in <= tx_shreg[0];
                    tx_shreg <= tx_shreg >> 1;
                end
                SHIFT: begin
                    cnt      <= cnt + CNT_W'(1);
                    // tx_shreg is zero-filled, so once all WIDTH bits have
                    // gone out chain_in naturally drives 0 for the tail.
                    if (state_next == SHIFT) begin
                        chain_in <= tx_shreg[0];
                    end
                    tx_shreg <= tx_shreg >> 1;
                    // Bit sent at cnt = k emerges at cnt = k + CHAIN_DEPTH;
                    // earlier cycles only see cleared chain content.
                    if (cnt >= CNT_CAP) begin
                        rx_shreg <= (rx_shreg >> 1) | (WIDTH'(chain_out) << (WIDTH - 1));
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.rsp_err   = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                busy          = 1'b0;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = rx_shreg;
                bus.rsp_err   = (rx_shreg != tx_copy);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_chain_ctrl
// Drives shift_chain_ctrl with the four-stage shift chain in loopback. Each
// issued request pushes its expected response into a queue; a monitor pops
// and compares on every response handshake. Directed checks cover reset,
// chain_in/chain_clr sequencing, latency, backpressure, a stuck-at-1 chain
// output and accept spacing; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_shift_chain_ctrl;
    import shift_chain_ctrl_pkg::*;

    localparam int unsigned W       = DEF_WIDTH;
    localparam int unsigned CD      = DEF_CHAIN_DEPTH;
    localparam int          LAT     = W + CD + 1;   // accept edge to rsp_valid
    localparam int          SPACING = W + CD + 3;   // minimum accept-to-accept

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          chain_clr;
    logic          chain_in;
    logic          chain_out;
    logic          busy;
    logic          fault;
    logic [CD-1:0] chain_q;

    int   n_vec    = 0;
    int   n_err    = 0;
    int   edge_cnt = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    shift_chain_ctrl_if #(.WIDTH(W)) bus ();

    shift_chain_ctrl #(.WIDTH(W), .CHAIN_DEPTH(CD)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .chain_clr (chain_clr),
        .chain_in  (chain_in),
        .chain_out (chain_out),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Four-stage shift chain in loopback; chain_clr is its synchronous clear.
    always @(posedge clock) begin
        if (chain_clr) chain_q <= '0;
        else           chain_q <= {chain_q[CD-2:0], chain_in};
    end
    assign chain_out = fault ? 1'b1 : chain_q[CD-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not seen within bound (t=%0t)", name, $time);
    endtask

    // Reference model: a healthy loopback returns the word sent; a chain whose
    // output is stuck at 1 returns all ones.
    task automatic push_exp(input logic [W-1:0] w, input logic flt);
        exp_t e;
        e.data = flt ? {W{1'b1}} : w;
        e.err  = (e.data != w);
        sb_q.push_back(e);
    endtask

    // Response monitor: compares on each handshake.
    always @(negedge clock) begin
        if (reset === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                fail("unexpected response");
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
                check("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
            end
        end
    end

    // Presents a request and returns 1 time unit after its accepting edge.
    task automatic start_req(input logic [W-1:0] w, output int acc_edge);
        bit ok = 1'b0;
        acc_edge      = -1;
        bus.req_valid = 1'b1;
        bus.req_data  = w;
        push_exp(w, fault);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clock);
            if (bus.req_ready) begin
                ok       = 1'b1;
                acc_edge = edge_cnt;
            end
        end
        #1 bus.req_valid = 1'b0;
        if (!ok) fail("accept timeout");
    endtask

    // Follows a transfer from the accept edge until rsp_valid is seen.
    task automatic await_rsp(input logic [W-1:0] w, input bit detail);
        int n        = 0;
        int clr_seen = 0;
        bit seen     = 1'b0;
        @(negedge clock);
        if (chain_clr) clr_seen++;
        if (detail) begin
            check("busy after accept", 32'(busy), 32'(1));
            check("chain_clr in CLEAR", 32'(chain_clr), 32'(1));
        end
        while (!seen && n < 40) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (chain_clr) clr_seen++;
            if (detail) begin
                if (n <= int'(W)) check($sformatf("chain_in bit%0d", n - 1), 32'(chain_in), 32'(w[n-1]));
                else              check("chain_in tail", 32'(chain_in), 32'(0));
            end
            if (bus.rsp_valid) seen = 1'b1;
        end
        if (!seen) fail("rsp_valid timeout");
        else       check("rsp latency", 32'(n), 32'(LAT));
        if (detail) check("chain_clr pulses", 32'(clr_seen), 32'(1));
    endtask

    // Completes the response handshake; returns 1 time unit after it.
    task automatic finish_rsp(input bit rand_bp);
        bit done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(posedge clock);
            if (bus.rsp_valid && bus.rsp_ready) done = 1'b1;
            else begin
                #1 bus.rsp_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        #1;
        if (!done) fail("handshake timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a1, a2, h_edge;
        logic [W-1:0] w;

        reset         = 1'b0;
        fault         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;

        // Reset values while held in reset.
        #12;
        check("rst req_ready", 32'(bus.req_ready), 32'(1));
        check("rst chain_clr", 32'(chain_clr), 32'(1));
        check("rst chain_in", 32'(chain_in), 32'(0));
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("rst rsp_data", 32'(bus.rsp_data), 32'(0));
        check("rst rsp_err", 32'(bus.rsp_err), 32'(0));
        check("rst busy", 32'(busy), 32'(0));
        #4 reset = 1'b1;
        @(posedge clock);
        #1;
        check("chain_clr after release", 32'(chain_clr), 32'(0));
        check("req_ready after release", 32'(bus.req_ready), 32'(1));

        // Loopback of 0xA5 with full sequencing detail.
        bus.rsp_ready = 1'b1;
        start_req(8'hA5, a1);
        await_rsp(8'hA5, 1'b1);
        finish_rsp(1'b0);

        // Backpressure: response held while 0x11 waits.
        bus.rsp_ready = 1'b0;
        start_req(8'h5A, a1);
        await_rsp(8'h5A, 1'b0);
        #1;
        bus.req_valid = 1'b1;
        bus.req_data  = 8'h11;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            @(negedge clock);
            check("bp rsp_valid", 32'(bus.rsp_valid), 32'(1));
            check("bp rsp_data", 32'(bus.rsp_data), 32'(8'h5A));
            check("bp rsp_err", 32'(bus.rsp_err), 32'(0));
            check("bp req_ready", 32'(bus.req_ready), 32'(0));
        end
        @(posedge clock);
        #1 bus.rsp_ready = 1'b1;
        @(posedge clock);
        h_edge = edge_cnt;
        #1;
        start_req(8'h11, a2);
        check("bp accept after handshake", 32'(a2 - h_edge), 32'(1));
        await_rsp(8'h11, 1'b0);
        finish_rsp(1'b0);

        // Chain output stuck at 1.
        fault = 1'b1;
        start_req(8'h3C, a1);
        await_rsp(8'h3C, 1'b1);
        finish_rsp(1'b0);
        fault = 1'b0;

        // Asynchronous reset mid-SHIFT (cnt = 5), then a clean transfer.
        start_req(8'hC3, a1);
        repeat (6) @(posedge clock);
        #3 reset = 1'b0;
        sb_q.delete();
        #1;
        check("mid rst req_ready", 32'(bus.req_ready), 32'(1));
        check("mid rst chain_clr", 32'(chain_clr), 32'(1));
        check("mid rst rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("mid rst busy", 32'(busy), 32'(0));
        check("mid rst chain_in", 32'(chain_in), 32'(0));
        @(posedge clock);
        #2;
        check("chain_clr held in reset", 32'(chain_clr), 32'(1));
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("chain_clr after mid release", 32'(chain_clr), 32'(0));
        start_req(8'h0F, a1);
        await_rsp(8'h0F, 1'b1);
        finish_rsp(1'b0);

        // Back-to-back at minimum spacing.
        start_req(8'h01, a1);
        await_rsp(8'h01, 1'b1);
        start_req(8'h80, a2);
        check("accept spacing", 32'(a2 - a1), 32'(SPACING));
        await_rsp(8'h80, 1'b1);
        finish_rsp(1'b0);

        // Randomized transfers with random backpressure and occasional fault.
        for (int k = 0; k < 20; k++) begin
            w             = W'($urandom);
            fault         = ($urandom_range(0, 5) == 0);
            bus.rsp_ready = 1'($urandom_range(0, 1));
            start_req(w, a1);
            await_rsp(w, 1'b0);
            finish_rsp(1'b1);
            fault = 1'b0;
        end

        repeat (2) @(posedge clock);
        #1;
        check("all responses returned", 32'(sb_q.size()), 32'(0));
        check("idle at end", 32'(busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
